// File: rtl/tl_pkg.sv
// Shared types and constants for the transaction-layer word counters.
// Holds the layer state encoding and the popcount helper used by the sum counter.
package tl_pkg;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 5;
  localparam int IDX_W   = 3;
  localparam int IDX_SUM = 4;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_INIT,
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  function automatic logic [CNT_W-1:0] count_ones(input logic [NUM_CH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/word_counter_responder_if.sv
// Read port of the word-counter responder: req/idx in, valid/contador out,
// plus the pending-request indication.
interface word_counter_responder_if;
  import tl_pkg::*;

  logic             req;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] contador;
  logic             valid;
  logic             busy_read;

  modport master (output req, idx, input contador, valid, busy_read);
  modport slave  (input req, idx, output contador, valid, busy_read);

endinterface

// File: rtl/word_counter_responder_word_counter.sv
// Single wrap-around word counter with synchronous clear and count enable.
module word_counter
  import tl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/word_counter_responder.sv
// Counts words popped from each output FIFO, runs the layer RESET/INIT/IDLE/ACTIVE
// state machine and answers counter reads with one cycle of latency.
module word_counter_responder
  import tl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic init,
  input  logic pop_0,
  input  logic pop_1,
  input  logic pop_2,
  input  logic pop_3,
  input  logic empty_0,
  input  logic empty_1,
  input  logic empty_2,
  input  logic empty_3,
  output logic idle,
  word_counter_responder_if.slave rd
);

  state_t state, next_state;
  logic                count_en, count_clr;
  logic [NUM_CH-1:0]   pop, empty, hit;
  logic                all_empty;
  logic [CNT_W-1:0]    cnt [NUM_CH];
  logic [CNT_W-1:0]    sum_cnt;

  logic                pending;
  logic [IDX_W-1:0]    pend_idx, rd_sel;
  logic [CNT_W-1:0]    rd_data, contador;
  logic                valid;
  logic                entering_init, capture_idle;

  assign pop       = {pop_3, pop_2, pop_1, pop_0};
  assign empty     = {empty_3, empty_2, empty_1, empty_0};
  assign all_empty = &empty;
  assign hit       = pop & ~empty & {NUM_CH{count_en}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RESET;
    else       state <= next_state;
  end

  // NOTE: combinational processes assign a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_RESET:  next_state = ST_INIT;
      ST_INIT:   if (!init) next_state = all_empty ? ST_IDLE : ST_ACTIVE;
      ST_IDLE:   if (init) next_state = ST_INIT;
                 else if (!all_empty) next_state = ST_ACTIVE;
      ST_ACTIVE: if (init) next_state = ST_INIT;
                 else if (all_empty) next_state = ST_IDLE;
      default:   next_state = ST_RESET;
    endcase
  end

  always_comb begin
    idle      = (state == ST_IDLE);
    count_en  = (state == ST_IDLE) || (state == ST_ACTIVE);
    count_clr = (state == ST_INIT);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    word_counter u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (count_clr),
      .en    (hit[i]),
      .cnt   (cnt[i])
    );
  end

  // Tracks the channel counters' sum modulo 2^CNT_W without an adder tree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          sum_cnt <= '0;
    else if (count_clr) sum_cnt <= '0;
    else if (count_en)  sum_cnt <= sum_cnt + count_ones(hit);
  end

  assign rd_sel = pending ? pend_idx : rd.idx;

  always_comb begin
    rd_data = '0;
    if (rd_sel < IDX_W'(NUM_CH))        rd_data = cnt[rd_sel[1:0]];
    else if (rd_sel == IDX_W'(IDX_SUM)) rd_data = sum_cnt;
  end

  // Leaving a live state for INIT discards any pending read.
  assign entering_init = (state == ST_IDLE || state == ST_ACTIVE) && next_state == ST_INIT;
  // A request arriving as ACTIVE drains into IDLE is answered immediately.
  assign capture_idle  = (state == ST_IDLE) || (state == ST_ACTIVE && next_state == ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= 1'b0;
      pend_idx <= '0;
      valid    <= 1'b0;
      contador <= '0;
    end else begin
      valid <= 1'b0;
      if (entering_init) begin
        pending <= 1'b0;
      end else if (pending) begin
        if (state == ST_IDLE) begin
          valid    <= 1'b1;
          contador <= rd_data;
          pending  <= 1'b0;
        end
      end else if (rd.req) begin
        if (capture_idle) begin
          valid    <= 1'b1;
          contador <= rd_data;
        end else begin
          pending  <= 1'b1;
          pend_idx <= rd.idx;
        end
      end
    end
  end

  assign rd.valid     = valid;
  assign rd.contador  = contador;
  assign rd.busy_read = pending;

endmodule

// File: tb/tb_word_counter_responder.sv
// Scoreboard bench for word_counter_responder: expected read data is queued when
// a request is driven and compared when valid pulses.
module tb_word_counter_responder;
  import tl_pkg::*;

  logic clk = 1'b0;
  logic reset, init, idle;
  logic [3:0] pop, empty;

  word_counter_responder_if rd();

  word_counter_responder dut (
    .clk     (clk),
    .reset   (reset),
    .init    (init),
    .pop_0   (pop[0]),
    .pop_1   (pop[1]),
    .pop_2   (pop[2]),
    .pop_3   (pop[3]),
    .empty_0 (empty[0]),
    .empty_1 (empty[1]),
    .empty_2 (empty[2]),
    .empty_3 (empty[3]),
    .idle    (idle),
    .rd      (rd.master)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Every valid pulse consumes one scoreboard entry; a pulse with none queued is an error.
  always @(negedge clk) begin
    if (!reset && rd.valid) begin
      if (exp_q.size() == 0) check("spurious_valid", 1, 0);
      else check("contador", int'(rd.contador), exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read(input int sel, input int exp);
    rd.req = 1'b1;
    rd.idx = IDX_W'(sel);
    exp_q.push_back(exp);
    step();
    rd.req = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 10;
    while (exp_q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int exp_pop[5];
    exp_pop = '{3, 2, 1, 0, 6};

    reset  = 1'b1;
    init   = 1'b1;
    pop    = 4'b0000;
    empty  = 4'b1111;
    rd.req = 1'b0;
    rd.idx = '0;
    #12;
    check("rst_valid", rd.valid, 0);
    check("rst_contador", rd.contador, 0);
    check("rst_idle", idle, 0);
    check("rst_busy", rd.busy_read, 0);

    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    check("init_idle", idle, 0);
    init = 1'b0;
    step();
    check("idle_after_init", idle, 1);
    for (int i = 0; i <= IDX_SUM; i++) read(i, 0);
    drain("drain_zero");

    // ch0 x3, ch1 x2, ch2 x1 while non-empty
    empty = 4'b0000;
    pop = 4'b0111; step();
    pop = 4'b0011; step();
    pop = 4'b0001; step();
    pop = 4'b0000; empty = 4'b1111; step();
    check("idle_after_drain", idle, 1);
    for (int i = 0; i <= IDX_SUM; i++) read(i, exp_pop[i]);
    drain("drain_counts");
    check("valid_single", rd.valid, 0);
    check("contador_hold", rd.contador, 6);

    // Request while ACTIVE stays pending until IDLE
    empty = 4'b1101; step();
    check("active_idle", idle, 0);
    read(1, 2);
    check("pend_busy", rd.busy_read, 1);
    check("pend_no_valid", rd.valid, 0);
    step();
    check("pend_no_valid2", rd.valid, 0);
    empty = 4'b1111; step();
    check("pend_no_valid3", rd.valid, 0);
    drain("drain_pending");
    check("pend_cleared", rd.busy_read, 0);

    // Pops on an empty FIFO are ignored
    pop = 4'b0100;
    repeat (5) step();
    pop = 4'b0000;
    read(2, 1);
    read(6, 0);
    drain("drain_empty_pop");

    // Entering INIT drops the pending request and clears counters
    empty = 4'b0111; step();
    rd.req = 1'b1; rd.idx = 3'd0; step(); rd.req = 1'b0;
    check("drop_busy_set", rd.busy_read, 1);
    init = 1'b1; step();
    check("drop_busy_clr", rd.busy_read, 0);
    step();
    init = 1'b0; empty = 4'b1111;
    repeat (4) step();
    check("drop_idle", idle, 1);
    for (int i = 0; i <= IDX_SUM; i++) read(i, 0);
    drain("drain_cleared");

    // 33 pops on ch0 wrap the 5-bit counters to 1
    empty = 4'b1110; pop = 4'b0001;
    repeat (33) step();
    pop = 4'b0000; empty = 4'b1111;
    step(); step();
    read(0, 1);
    read(IDX_SUM, 1);
    read(1, 0);
    drain("drain_wrap");

    // Asynchronous reset mid-read clears valid at once
    rd.req = 1'b1; rd.idx = 3'd0;
    exp_q.push_back(1);
    @(posedge clk);
    #2;
    check("async_valid_pre", rd.valid, 1);
    reset = 1'b1;
    #1;
    check("async_valid", rd.valid, 0);
    check("async_contador", rd.contador, 0);
    check("async_idle", idle, 0);
    rd.req = 1'b0;
    exp_q.delete();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
